// File: rtl/kadai4_pkg.sv
// kadai4 accumulator shared types: FSM state codes, count width and
// a saturating add helper reused by the host-side checker.
package kadai4_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam int CNT_W = 8;

  // Operands are at most w bits wide; result is {ovf, sum} in 33 bits.
  function automatic logic [32:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input int          w
  );
    logic [32:0] s;
    logic [31:0] m;
    logic        c;
    m = (w >= 32) ? 32'hFFFF_FFFF
                  : ((32'd1 << w) - 32'd1);
    s = {1'b0, a} + {1'b0, b};
    c = s[32] | (|(s[31:0] & ~m));
    return {c, (c ? m : s[31:0])};
  endfunction

endpackage

// File: rtl/kadai4_acc_add.sv
// Accumulator adder: wraps by default, saturates with KADAI4_ACC_SAT_EN.
// carry flags any overflow out of W bits in either build.
module kadai4_acc_add
  import kadai4_pkg::*;
#(
  parameter int W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

`ifdef KADAI4_ACC_SAT_EN
  logic [32:0] r;
  logic        unused_r;

  assign r        = sat_add(32'(a), 32'(b), W);
  assign sum      = r[W-1:0];
  assign carry    = r[32];
  assign unused_r = ^r;
`else
  assign {carry, sum} = {1'b0, a} + {1'b0, b};
`endif

endmodule

// File: rtl/kadai4_acc.sv
// kadai4 frame accumulator: pops FIFO products, emits frame sums.
// Define KADAI4_ACC_SAT_EN for a saturating accumulator.
module kadai4_acc
  import kadai4_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 20
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FIFO_EMPTY,
  output logic             FIFO_RD,
  input  logic [15:0]      FIFO_DOUT,
  input  logic             FIFO_VALID,
  output logic [ACC_W-1:0] SUM,
  output logic             SUM_VALID,
  input  logic             SUM_READY,
  output logic [CNT_W-1:0] CNT,
  output logic             OVF
);

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] nxt;
  logic             carry;
  logic             last;

  assign addend = ACC_W'(FIFO_DOUT);
  assign last   = (CNT == CNT_W'(FRAME_LEN - 1));

  kadai4_acc_add #(
    .W(ACC_W)
  ) u_add (
    .a    (acc),
    .b    (addend),
    .sum  (nxt),
    .carry(carry)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      FIFO_RD   <= 1'b0;
      SUM       <= '0;
      SUM_VALID <= 1'b0;
      CNT       <= '0;
      OVF       <= 1'b0;
      acc       <= '0;
    end else begin
      FIFO_RD <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!FIFO_EMPTY) begin
            state   <= S_REQ;
            FIFO_RD <= 1'b1;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (FIFO_VALID) begin
            acc <= nxt;
            if (carry) OVF <= 1'b1;
            if (last) begin
              SUM       <= nxt;
              SUM_VALID <= 1'b1;
              CNT       <= '0;
              state     <= S_OUT;
            end else begin
              CNT   <= CNT + 8'd1;
              state <= S_IDLE;
            end
          end
        end
        default: begin
          if (SUM_READY) begin
            SUM_VALID <= 1'b0;
            acc       <= '0;
            OVF       <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kadai4_acc.sv
// Scoreboard bench for kadai4_acc with a behavioural FIFO model.
// Run with ACC_W=16 so the overflow paths are reachable.
module tb_kadai4_acc;

  localparam int FL = 8;
  localparam int AW = 16;
  localparam longint MAXV = (longint'(1) << AW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          FIFO_EMPTY;
  logic          FIFO_RD;
  logic [15:0]   FIFO_DOUT;
  logic          FIFO_VALID;
  logic [AW-1:0] SUM;
  logic          SUM_VALID;
  logic          SUM_READY;
  logic [7:0]    CNT;
  logic          OVF;

  int n_tests = 0;
  int n_fail  = 0;
  int n_push  = 0;
  int rd_cnt  = 0;
  logic starve = 1'b0;

  logic [15:0] fifo_q[$];
  logic [AW:0] exp_q[$];

  kadai4_acc #(
    .FRAME_LEN(FL),
    .ACC_W    (AW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_RD   (FIFO_RD),
    .FIFO_DOUT (FIFO_DOUT),
    .FIFO_VALID(FIFO_VALID),
    .SUM       (SUM),
    .SUM_VALID (SUM_VALID),
    .SUM_READY (SUM_READY),
    .CNT       (CNT),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(int k, int i);
    case (k)
      0:       return 16'h1FA4;
      1:       return 16'(i + 1);
      2:       return 16'hFFFF;
      3:       return (i < 5) ? 16'hFFFF : 16'h0000;
      default: return (i % 2 == 1) ? 16'hFFFF : 16'h0001;
    endcase
  endfunction

  task automatic push_frame(input int k);
    longint s = 0;
    logic   o = 1'b0;
    logic [15:0] d;
    for (int i = 0; i < FL; i++) begin
      d = pat(k, i);
      fifo_q.push_back(d);
      n_push++;
      s = s + longint'(d);
      if (s > MAXV) begin
        o = 1'b1;
`ifdef KADAI4_ACC_SAT_EN
        s = MAXV;
`else
        s = s - (MAXV + 1);
`endif
      end
    end
    exp_q.push_back({o, s[AW-1:0]});
  endtask

  // FIFO model: RD sampled mid-cycle, data valid the following cycle.
  initial begin
    logic rd;
    logic rd_prev = 1'b0;
    logic emp_prev = 1'b1;
    logic have;
    logic [15:0] d;
    FIFO_EMPTY = 1'b1;
    FIFO_VALID = 1'b0;
    FIFO_DOUT  = '0;
    forever begin
      @(negedge CLK);
      rd   = FIFO_RD;
      have = 1'b0;
      d    = '0;
      if (rd) begin
        rd_cnt++;
        check("rd_when_empty", 64'(emp_prev), 64'd0);
        check("rd_pulse", 64'(rd_prev), 64'd0);
        if (fifo_q.size() > 0) begin
          d    = fifo_q.pop_front();
          have = 1'b1;
        end
      end
      rd_prev = rd;
      @(posedge CLK);
      #1;
      FIFO_VALID = have;
      FIFO_DOUT  = d;
      emp_prev   = FIFO_EMPTY;
      FIFO_EMPTY = (fifo_q.size() == 0) || starve;
    end
  end

  // Monitor: compare each accepted frame sum against the scoreboard.
  initial begin
    logic sv_prev = 1'b0;
    logic fv_prev = 1'b0;
    logic [AW:0] e;
    forever begin
      @(negedge CLK);
      if (SUM_VALID && !sv_prev)
        check("sum_latency", 64'(fv_prev), 64'd1);
      if (SUM_VALID && SUM_READY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sum", 64'(SUM), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("sum", 64'(SUM), 64'(e[AW-1:0]));
          check("ovf", 64'(OVF), 64'(e[AW]));
        end
      end
      sv_prev = SUM_VALID;
      fv_prev = FIFO_VALID;
    end
  end

  initial begin
    int t;
    logic bp_ok;
    RST       = 1'b0;
    SUM_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_sum", 64'(SUM), 64'd0);
    check("rst_sum_valid", 64'(SUM_VALID), 64'd0);
    check("rst_cnt", 64'(CNT), 64'd0);
    check("rst_ovf", 64'(OVF), 64'd0);
    check("rst_rd", 64'(FIFO_RD), 64'd0);
    RST = 1'b1;

    for (int i = 0; i < 3; i++) begin
      fifo_q.push_back(16'h1FA4);
      n_push++;
    end
    t = 0;
    while (CNT != 8'd3 && t < 200) begin
      @(posedge CLK);
      #1;
      t++;
    end
    check("mid_cnt", 64'(CNT), 64'd3);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("mid_rst_cnt", 64'(CNT), 64'd0);
    check("mid_rst_sum", 64'(SUM), 64'd0);
    check("mid_rst_valid", 64'(SUM_VALID), 64'd0);
    check("mid_rst_ovf", 64'(OVF), 64'd0);
    RST = 1'b1;

    push_frame(0);
    push_frame(1);

    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge CLK);
      #1;
      t++;
    end
    check("nominal_drain", 64'(exp_q.size()), 64'd0);

    SUM_READY = 1'b0;
    push_frame(0);
    push_frame(1);
    t = 0;
    while (!SUM_VALID && t < 200) begin
      @(posedge CLK);
      #1;
      t++;
    end
    check("bp_valid", 64'(SUM_VALID), 64'd1);
    bp_ok = 1'b1;
    repeat (10) begin
      @(posedge CLK);
      #1;
      if (FIFO_RD || !SUM_VALID || SUM !== 16'hFD20)
        bp_ok = 1'b0;
    end
    check("bp_hold", 64'(bp_ok), 64'd1);
    check("bp_fifo_full", 64'(FIFO_EMPTY), 64'd0);
    SUM_READY = 1'b1;
    @(posedge CLK);
    #1;
    check("bp_release", 64'(SUM_VALID), 64'd0);

    push_frame(2);
    push_frame(3);
    push_frame(4);
    push_frame(1);

    push_frame(0);
    push_frame(4);
    repeat (300) begin
      @(posedge CLK);
      #1;
      starve = 1'($urandom_range(0, 1));
    end
    starve = 1'b0;

    t = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0)
           && t < 3000) begin
      @(posedge CLK);
      #1;
      t++;
    end
    repeat (4) @(posedge CLK);
    #1;
    check("final_drain", 64'(exp_q.size()), 64'd0);
    check("fifo_drain", 64'(fifo_q.size()), 64'd0);
    check("rd_count", 64'(rd_cnt), 64'(n_push));
    check("idle_valid", 64'(SUM_VALID), 64'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
